// File: rtl/mas_alu_shift_pipe_if.sv
// Handshake and data bundle for the MAS ALU pipelined barrel shifter.
// master: operand dispatch / result consumer side; slave: the shifter.
interface mas_alu_shift_pipe_if #(
    parameter int BLEN  = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [BLEN-1:0]  op1;
    logic [BLEN-1:0]  op2;
    logic [2:0]       mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [BLEN-1:0]  res;
    logic [TAG_W-1:0] out_tag;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, op1, op2, mode, in_tag, out_ready,
        input  in_ready, out_valid, res, out_tag, zero, err
    );

    modport slave (
        input  in_valid, op1, op2, mode, in_tag, out_ready,
        output in_ready, out_valid, res, out_tag, zero, err
    );
endinterface

// File: rtl/mas_alu_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with a global-stall valid/ready pipeline.
// Right shifts and ROR reuse one left shifter by reversing the operand on entry and the result on exit.
module mas_alu_shift_pipe #(
    parameter int BLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mas_alu_shift_pipe_if.slave      io_bus
);
    localparam int SHW = $clog2(BLEN);
    localparam int K   = (SHW + STAGES - 1) / STAGES;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    function automatic logic [BLEN-1:0] f_rev(input logic [BLEN-1:0] d);
        logic [BLEN-1:0] r;
        for (int b = 0; b < BLEN; b++) r[b] = d[BLEN-1-b];
        return r;
    endfunction

    function automatic logic f_is_right(input logic [2:0] m);
        return (m == MODE_SRL) || (m == MODE_SRA) || (m == MODE_ROR);
    endfunction

    function automatic logic f_is_rot(input logic [2:0] m);
        return (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

    function automatic logic f_is_illegal(input logic [2:0] m);
        return m > MODE_ROR;
    endfunction

    // Amount bits handled by the stage covering levels [lo, hi).
    function automatic logic [SHW-1:0] f_mask(input int lo, input int hi);
        logic [SHW-1:0] m;
        for (int b = 0; b < SHW; b++) m[b] = (b >= lo) && (b < hi);
        return m;
    endfunction

    logic w_advance;
    logic r_zero;
    logic r_err;
    logic w_unused_op2;

    assign w_unused_op2 = ^io_bus.op2[BLEN-1:SHW];

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            localparam int LO = i * K;
            localparam int HI = ((i + 1) * K < SHW) ? (i + 1) * K : SHW;
            localparam logic [SHW-1:0] LEVEL_MASK = f_mask(LO, HI);

            logic             w_valid;
            logic [BLEN-1:0]  w_src;
            logic [SHW-1:0]   w_amt;
            logic [2:0]       w_mode;
            logic             w_fill;
            logic [TAG_W-1:0] w_tag;
            logic [SHW-1:0]   w_sel;
            logic             w_rot;
            logic [BLEN-1:0]  w_shift;
            logic [BLEN-1:0]  w_out;

            logic             r_valid;
            logic [BLEN-1:0]  r_data;
            logic [TAG_W-1:0] r_tag;

            if (i == 0) begin : g_src
                assign w_valid = io_bus.in_valid;
                assign w_src   = f_is_right(io_bus.mode) ? f_rev(io_bus.op1) : io_bus.op1;
                assign w_amt   = io_bus.op2[SHW-1:0];
                assign w_mode  = io_bus.mode;
                assign w_fill  = (io_bus.mode == MODE_SRA) & io_bus.op1[BLEN-1];
                assign w_tag   = io_bus.in_tag;
            end else begin : g_src
                assign w_valid = g_stage[i-1].r_valid;
                assign w_src   = g_stage[i-1].r_data;
                assign w_amt   = g_stage[i-1].g_ctl.r_amt;
                assign w_mode  = g_stage[i-1].g_ctl.r_mode;
                assign w_fill  = g_stage[i-1].g_ctl.r_fill;
                assign w_tag   = g_stage[i-1].r_tag;
            end

            assign w_sel = w_amt & LEVEL_MASK;
            assign w_rot = f_is_rot(w_mode);

            // NOTE: blocking '=' here chains the log-shifter levels within one cycle; always_ff blocks use '<='.
            always_comb begin
                w_shift = w_src;
                for (int b = 0; b < SHW; b++) begin
                    if (w_sel[b]) begin
                        if (w_rot)
                            w_shift = (w_shift << (1 << b)) | (w_shift >> (BLEN - (1 << b)));
                        else
                            w_shift = (w_shift << (1 << b))
                                    | ({BLEN{w_fill}} & ~({BLEN{1'b1}} << (1 << b)));
                    end
                end
            end

            if (i == STAGES - 1) begin : g_last
                assign w_out = f_is_illegal(w_mode) ? '0
                             : (f_is_right(w_mode) ? f_rev(w_shift) : w_shift);

                // Flags only update when a real op lands, so they hold across bubbles.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_zero <= 1'b0;
                        r_err  <= 1'b0;
                    end else if (w_advance && w_valid) begin
                        r_zero <= (w_out == '0);
                        r_err  <= f_is_illegal(w_mode);
                    end
                end
            end else begin : g_mid
                assign w_out = w_shift;
            end

            // NOTE: data and tag registers are reset too, since res and out_tag must read zero after reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_tag   <= '0;
                end else if (w_advance) begin
                    r_valid <= w_valid;
                    r_data  <= w_out;
                    r_tag   <= w_tag;
                end
            end

            if (i < STAGES - 1) begin : g_ctl
                logic [SHW-1:0] r_amt;
                logic [2:0]     r_mode;
                logic           r_fill;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_amt  <= '0;
                        r_mode <= MODE_SLL;
                        r_fill <= 1'b0;
                    end else if (w_advance) begin
                        r_amt  <= w_amt;
                        r_mode <= w_mode;
                        r_fill <= w_fill;
                    end
                end
            end
        end
    endgenerate

    // Global stall: the whole pipe moves only when the output slot is free or being drained.
    assign w_advance        = ~g_stage[STAGES-1].r_valid | io_bus.out_ready;
    assign io_bus.in_ready  = w_advance;
    assign io_bus.out_valid = g_stage[STAGES-1].r_valid;
    assign io_bus.res       = g_stage[STAGES-1].r_data;
    assign io_bus.out_tag   = g_stage[STAGES-1].r_tag;
    assign io_bus.zero      = r_zero;
    assign io_bus.err       = r_err;
endmodule

// File: tb/tb_mas_alu_shift_pipe.sv
// Directed bench for mas_alu_shift_pipe at (32,2) plus a random sweep of (8,1), (32,5), (64,3)
// against a bit-level reference model.
module tb_mas_alu_shift_pipe;
    localparam int N_VEC = 1000;
    localparam logic [2:0] SLL = 3'd0, SRL = 3'd1, SRA = 3'd2, ROL = 3'd3, ROR = 3'd4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mas_alu_shift_pipe_if #(.BLEN(32), .TAG_W(4)) bus   ();
    mas_alu_shift_pipe_if #(.BLEN(8),  .TAG_W(4)) bus_a ();
    mas_alu_shift_pipe_if #(.BLEN(32), .TAG_W(4)) bus_b ();
    mas_alu_shift_pipe_if #(.BLEN(64), .TAG_W(4)) bus_c ();

    mas_alu_shift_pipe #(.BLEN(32), .STAGES(2), .TAG_W(4)) dut   (.clk(clk), .rst_n(rst_n), .io_bus(bus));
    mas_alu_shift_pipe #(.BLEN(8),  .STAGES(1), .TAG_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .io_bus(bus_a));
    mas_alu_shift_pipe #(.BLEN(32), .STAGES(5), .TAG_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .io_bus(bus_b));
    mas_alu_shift_pipe #(.BLEN(64), .STAGES(3), .TAG_W(4)) dut_c (.clk(clk), .rst_n(rst_n), .io_bus(bus_c));

    logic [127:0] v_op1   [N_VEC];
    logic [31:0]  v_op2   [N_VEC];
    logic [2:0]   v_mode  [N_VEC];
    logic [3:0]   v_tag   [N_VEC];
    logic         v_valid [N_VEC];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.in_valid   = 1'b0; bus.op1   = '0; bus.op2   = '0; bus.mode   = SLL; bus.in_tag   = '0; bus.out_ready   = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.op1 = '0; bus_a.op2 = '0; bus_a.mode = SLL; bus_a.in_tag = '0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.op1 = '0; bus_b.op2 = '0; bus_b.mode = SLL; bus_b.in_tag = '0; bus_b.out_ready = 1'b1;
        bus_c.in_valid = 1'b0; bus_c.op1 = '0; bus_c.op2 = '0; bus_c.mode = SLL; bus_c.in_tag = '0; bus_c.out_ready = 1'b1;
    endtask

    // Bit-by-bit reference: each result bit names the source bit it comes from.
    function automatic logic [127:0] ref_shift(input logic [127:0] a, input int s,
                                               input logic [2:0] m, input int blen);
        logic [127:0] r = '0;
        for (int b = 0; b < blen; b++) begin
            case (m)
                SLL: r[b] = (b - s >= 0) ? a[b - s] : 1'b0;
                SRL: r[b] = (b + s < blen) ? a[b + s] : 1'b0;
                SRA: r[b] = (b + s < blen) ? a[b + s] : a[blen - 1];
                ROL: r[b] = a[(b - s + blen) % blen];
                ROR: r[b] = a[(b + s) % blen];
                default: r[b] = 1'b0;
            endcase
        end
        return r;
    endfunction

    // One op on the (32,2) instance: idle pipe, two-cycle latency, then drained.
    task automatic run_op(input string name, input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] t, input logic [31:0] er, input logic ez, input logic ee);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1; bus.op1 = a; bus.op2 = b; bus.mode = m; bus.in_tag = t;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early: out_valid=%b one cycle after issue, want 0", name, bus.out_valid);
        end
        step();
        checks++;
        if ({bus.out_valid, bus.res, bus.out_tag, bus.zero, bus.err} !== {1'b1, er, t, ez, ee}) begin
            errors++;
            $display("FAIL %s: got v=%b res=%h tag=%0d zero=%b err=%b, want v=1 res=%h tag=%0d zero=%b err=%b",
                     name, bus.out_valid, bus.res, bus.out_tag, bus.zero, bus.err, er, t, ez, ee);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        #1;
        checks++;
        if ({bus.out_valid, bus.res, bus.out_tag, bus.zero, bus.err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b res=%h tag=%0d zero=%b err=%b, want all 0",
                     bus.out_valid, bus.res, bus.out_tag, bus.zero, bus.err);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_shift_modes();
        run_op("sll_basic", SLL, 32'h0000_00F1, 32'd4, 4'd3, 32'h0000_0F10, 1'b0, 1'b0);
        run_op("sra_neg",   SRA, 32'h8000_0010, 32'd4, 4'd4, 32'hF800_0001, 1'b0, 1'b0);
        run_op("srl_neg",   SRL, 32'h8000_0010, 32'd4, 4'd5, 32'h0800_0001, 1'b0, 1'b0);
        run_op("sra_pos",   SRA, 32'h7000_0000, 32'd8, 4'd6, 32'h0070_0000, 1'b0, 1'b0);
    endtask

    task automatic test_rotate_mask();
        run_op("rol_wrap",   ROL, 32'h8000_0001, 32'd1,    4'd7,  32'h0000_0003, 1'b0, 1'b0);
        run_op("ror_masked", ROR, 32'h0000_0001, 32'h21,   4'd8,  32'h8000_0000, 1'b0, 1'b0);
        run_op("sll_zero",   SLL, 32'hDEAD_BEEF, 32'd0,    4'd9,  32'hDEAD_BEEF, 1'b0, 1'b0);
        run_op("sra_zero",   SRA, 32'h8765_4321, 32'hFFE0, 4'd10, 32'h8765_4321, 1'b0, 1'b0);
        run_op("ror_31",     ROR, 32'h0000_0001, 32'd31,   4'd11, 32'h0000_0002, 1'b0, 1'b0);
        run_op("sll_31",     SLL, 32'h0000_0003, 32'd31,   4'd12, 32'h8000_0000, 1'b0, 1'b0);
    endtask

    task automatic test_flags();
        run_op("illegal_111", 3'b111, 32'hFFFF_FFFF, 32'd3, 4'd13, 32'h0, 1'b1, 1'b1);
        run_op("illegal_101", 3'b101, 32'h1234_5678, 32'd0, 4'd14, 32'h0, 1'b1, 1'b1);
        run_op("sll_to_zero", SLL,    32'h8000_0000, 32'd1, 4'd15, 32'h0, 1'b1, 1'b0);
        run_op("after_zero",  SRL,    32'h0000_0100, 32'd8, 4'd1,  32'h1, 1'b0, 1'b0);
    endtask

    // Six ops with tags 0..5, out_ready low in cycles 3..5; output cycles are hand-derived.
    task automatic test_back_to_back();
        int          next = 0;
        int          n_out = 0;
        logic        acc = 1'b0;
        logic        stalled = 1'b0;
        logic [31:0] prev_res = '0;
        logic [3:0]  prev_tag = '0;
        logic [31:0] er;
        int          exp_cycle [6] = '{2, 6, 7, 8, 9, 10};
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            if (acc) next++;
            bus.out_ready = !(c inside {[3:5]});
            bus.in_valid  = (next < 6);
            bus.op1 = 32'(next + 1); bus.op2 = 32'(next); bus.mode = SLL; bus.in_tag = 4'(next);
            #1;
            if (stalled) begin
                checks++;
                if (bus.res !== prev_res || bus.out_tag !== prev_tag) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d: res=%h tag=%0d, want res=%h tag=%0d",
                             c, bus.res, bus.out_tag, prev_res, prev_tag);
                end
            end
            if (c inside {[3:5]}) begin
                checks++;
                if ({bus.in_ready, bus.out_valid, bus.out_tag} !== {1'b0, 1'b1, 4'd1}) begin
                    errors++;
                    $display("FAIL stall_ready cycle %0d: in_ready=%b out_valid=%b tag=%0d, want 0 1 1",
                             c, bus.in_ready, bus.out_valid, bus.out_tag);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (n_out >= 6) begin
                    errors++;
                    $display("FAIL b2b_extra cycle %0d: unexpected output tag=%0d, want none", c, bus.out_tag);
                end else begin
                    er = 32'(n_out + 1) << n_out;
                    if (bus.res !== er || bus.out_tag !== 4'(n_out) || c != exp_cycle[n_out]) begin
                        errors++;
                        $display("FAIL b2b_out %0d: res=%h tag=%0d cycle=%0d, want res=%h tag=%0d cycle=%0d",
                                 n_out, bus.res, bus.out_tag, c, er, n_out, exp_cycle[n_out]);
                    end
                end
                n_out++;
            end
            stalled  = bus.out_valid && !bus.out_ready;
            prev_res = bus.res;
            prev_tag = bus.out_tag;
            acc      = bus.in_valid && bus.in_ready;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (n_out != 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want 6", n_out);
        end
    endtask

    task automatic test_reset_mid_flight();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.op1 = 32'h12; bus.op2 = 32'd4; bus.mode = SLL; bus.in_tag = 4'd9;
        step();
        bus.op1 = 32'h5; bus.op2 = 32'd1; bus.mode = ROL; bus.in_tag = 4'd10;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.res, bus.out_tag} !== {1'b1, 32'h120, 4'd9}) begin
            errors++;
            $display("FAIL pre_reset: v=%b res=%h tag=%0d, want v=1 res=00000120 tag=9",
                     bus.out_valid, bus.res, bus.out_tag);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.res, bus.out_tag, bus.zero, bus.err} !== '0) begin
            errors++;
            $display("FAIL async_reset: v=%b res=%h tag=%0d zero=%b err=%b, want all 0",
                     bus.out_valid, bus.res, bus.out_tag, bus.zero, bus.err);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: in_ready=%b, want 1", bus.in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_result cycle %0d: out_valid=%b tag=%0d, want out_valid 0",
                         c, bus.out_valid, bus.out_tag);
            end
            step();
        end
    endtask

    task automatic sweep_cmp(input string name, input int i, input int stages, input int blen,
                             input logic ov, input logic [127:0] r, input logic [3:0] t,
                             input logic z, input logic er);
        int           j;
        int           s;
        logic [127:0] e;
        j = i - stages;
        checks++;
        if (j >= 0 && j < N_VEC && v_valid[j]) begin
            s = int'(v_op2[j] & 32'(blen - 1));
            e = ref_shift(v_op1[j], s, v_mode[j], blen);
            if ({ov, r, t, z, er} !== {1'b1, e, v_tag[j], (e == '0), 1'b0}) begin
                errors++;
                $display("FAIL %s vec %0d: v=%b res=%h tag=%0d zero=%b err=%b, want v=1 res=%h tag=%0d zero=%b err=0",
                         name, j, ov, r, t, z, er, e, v_tag[j], (e == '0));
            end
        end else if (ov !== 1'b0) begin
            errors++;
            $display("FAIL %s cycle %0d: out_valid=%b, want 0", name, i, ov);
        end
    endtask

    task automatic test_param_sweep();
        for (int i = 0; i < N_VEC + 6; i++) begin
            step();
            sweep_cmp("sweep_8_1",  i, 1, 8,  bus_a.out_valid, 128'(bus_a.res), bus_a.out_tag, bus_a.zero, bus_a.err);
            sweep_cmp("sweep_32_2", i, 2, 32, bus.out_valid,   128'(bus.res),   bus.out_tag,   bus.zero,   bus.err);
            sweep_cmp("sweep_32_5", i, 5, 32, bus_b.out_valid, 128'(bus_b.res), bus_b.out_tag, bus_b.zero, bus_b.err);
            sweep_cmp("sweep_64_3", i, 3, 64, bus_c.out_valid, 128'(bus_c.res), bus_c.out_tag, bus_c.zero, bus_c.err);
            if (i < N_VEC) begin
                v_valid[i] = ($urandom_range(0, 9) != 0);
                v_op1[i]   = {$urandom(), $urandom(), $urandom(), $urandom()};
                v_op2[i]   = $urandom();
                v_mode[i]  = 3'($urandom_range(0, 4));
                v_tag[i]   = 4'($urandom());
                bus_a.in_valid = v_valid[i]; bus_a.op1 = v_op1[i][7:0];  bus_a.op2 = v_op2[i][7:0];
                bus_a.mode = v_mode[i]; bus_a.in_tag = v_tag[i];
                bus.in_valid   = v_valid[i]; bus.op1   = v_op1[i][31:0]; bus.op2   = v_op2[i];
                bus.mode   = v_mode[i]; bus.in_tag   = v_tag[i];
                bus_b.in_valid = v_valid[i]; bus_b.op1 = v_op1[i][31:0]; bus_b.op2 = v_op2[i];
                bus_b.mode = v_mode[i]; bus_b.in_tag = v_tag[i];
                bus_c.in_valid = v_valid[i]; bus_c.op1 = v_op1[i][63:0]; bus_c.op2 = 64'(v_op2[i]);
                bus_c.mode = v_mode[i]; bus_c.in_tag = v_tag[i];
            end else begin
                idle_all();
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift_modes();
        test_rotate_mask();
        test_flags();
        test_back_to_back();
        test_reset_mid_flight();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mas_alu_shift_pipe.md
Name: mas_alu_shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the MAS ALU.
- Successor to the single-cycle left-shift unit: adds logical/arithmetic right shift and rotates, configurable width and pipeline depth, valid/ready handshakes with backpressure, tag passthrough and result flags.
- Sits between the ALU operand dispatch and the ALU result mux. Its shift datapath is the same one that feeds the shift-class opcodes.

Parameters:
- BLEN, 32: operand/result width in bits; power of two, 8..128.
- STAGES, 2: pipeline register stages, which is also the latency; 1..$clog2(BLEN).
- TAG_W, 4: width of the opaque tag carried alongside each operation.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operation presented.
- in_ready, output, 1: unit accepts the operation this cycle.
- op1, input, BLEN: value to shift.
- op2, input, BLEN: shift amount. Only op2[SHW-1:0] is used, where SHW = $clog2(BLEN); upper bits are ignored.
- mode, input, 3: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101..111 illegal.
- in_tag, input, TAG_W: tag.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- res, output, BLEN: shifted result.
- out_tag, output, TAG_W: tag of the op that produced res.
- zero, output, 1: res == 0.
- err, output, 1: op was issued with an illegal mode.

Behaviour:
- Reset (async assert, sync deassert):
  - All stage valid bits clear.
  - out_valid=0, res=0, out_tag=0, zero=0, err=0.
  - in_ready=1 from the first cycle after reset release.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Global stall pipeline:
  - advance = ~out_valid | out_ready.
  - in_ready = advance. in_ready must not depend combinationally on in_valid.
  - When advance=1, every stage loads from its predecessor. Stage 0 loads the input and takes valid = in_valid.
  - When advance=0, all stages hold, including data, tag and valid.
  - Bubbles are not collapsed. An empty slot still moves only on advance.
- Latency:
  - An op accepted in cycle N appears on out_valid/res in cycle N+STAGES if no stall occurs.
  - Each stall cycle adds exactly one cycle.
  - Throughput is one op per cycle with out_ready held high.
- Arithmetic, with s = op2[SHW-1:0]:
  - SLL: op1 << s, zero fill.
  - SRL: op1 >> s, zero fill.
  - SRA: op1 >>> s, fill with op1[BLEN-1].
  - ROL: (op1 << s) | (op1 >> (BLEN-s)), with s=0 giving op1 unchanged.
  - ROR: mirror of ROL.
  - s=0 gives op1 unchanged for every legal mode.
- Datapath split:
  - The SHW log-shifter levels are divided across the STAGES registers. Stage i handles amount bits [i*K, min((i+1)*K, SHW)-1], where K = ceil(SHW/STAGES).
  - Mode and the remaining amount bits travel with the data.
  - Rotates and right shifts may be implemented by bit reversal around a single left shifter. Only the final res value is checked.
- Flags:
  - Illegal mode: res=0, err=1, zero=1. The op still occupies its slot and still completes with normal latency.
  - zero and err are registered with res and are valid only while out_valid=1.
  - While out_valid=0 they hold their last value; the bench must not check them then.
- Stall stability: while out_valid=1 and out_ready=0, res, out_tag, zero and err are stable.
- Reset mid-operation: all in-flight ops are discarded with no output, and every output returns to its reset value asynchronously.
- Simultaneous events: an input transfer and an output transfer in the same cycle are legal. This is the normal full-throughput case.

Test Plan (BLEN=32, STAGES=2, TAG_W=4):
- Shift mode spot checks:
  - SLL op1=0x0000_00F1, op2=4, tag=3 -> two cycles later out_valid=1, res=0x0000_0F10, out_tag=3, zero=0, err=0.
  - SRA op1=0x8000_0010, op2=4 -> res=0xF800_0001.
  - SRL with the same operands -> res=0x0800_0001.
- Rotate and amount masking:
  - ROL op1=0x8000_0001, op2=1 -> res=0x0000_0003.
  - ROR op1=0x0000_0001, op2=0x21 (masked to s=1) -> res=0x8000_0000.
  - SLL op2=0 -> res=op1.
- Backpressure: stream 6 back-to-back ops with tags 0..5 while out_ready=0 for cycles 3-5.
  - in_ready drops while stalled.
  - res and out_tag are held stable.
  - All 6 results emerge in order with no loss or duplication.
  - Full throughput resumes once out_ready returns to 1.
- Illegal and zero results:
  - mode=111, op1=0xFFFF_FFFF -> res=0, err=1, zero=1.
  - SLL op1=0x8000_0000, op2=1 -> res=0, zero=1, err=0.
- Reset mid-flight: assert rst_n low with 2 ops in flight -> out_valid=0 and res=0 immediately; no stale result appears after release; in_ready=1 on the next cycle.
- Parameter sweep: random legal ops with 1000 vectors per configuration, checked against a combinational reference model with latency equal to STAGES, for (BLEN,STAGES) = (8,1), (32,5), (64,3).
